// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin time-sharing controller for one 4x4 multiplier
module mult_share_arb #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_out,
  output logic               rsp0_valid,
  output logic [2*WIDTH-1:0] rsp0_data,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  output logic [2*WIDTH-1:0] rsp1_data,
  input  logic               rsp1_ready,
  output logic               busy,
  output logic [7:0]         op_count
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t             state, state_nxt;
  logic               owner;
  logic               last_grant;
  logic [2*WIDTH-1:0] result;
  logic               grant0, grant1;
  logic               rsp_fire;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  // Response handshake of the current owner; the other port's ready is ignored
  always_comb begin
    rsp_fire = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0_ready | req1_ready) state_nxt = MUL;
      MUL:     state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; ready is also forced low while reset is asserted
  always_comb begin
    busy       = (state != IDLE);
    req0_ready = rst_n & (state == IDLE) & grant0;
    req1_ready = rst_n & (state == IDLE) & grant1;
    rsp0_valid = (state == RESP) & ~owner;
    rsp1_valid = (state == RESP) & owner;
    rsp0_data  = rsp0_valid ? result : '0;
    rsp1_data  = rsp1_valid ? result : '0;
  end

  // Datapath: latch winner operands, capture product, count completions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a      <= '0;
      mul_b      <= '0;
      result     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_count   <= 8'd0;
    end else begin
      if (req0_ready) begin
        mul_a      <= req0_a;
        mul_b      <= req0_b;
        owner      <= 1'b0;
        last_grant <= 1'b0;
      end else if (req1_ready) begin
        mul_a      <= req1_a;
        mul_b      <= req1_b;
        owner      <= 1'b1;
        last_grant <= 1'b1;
      end
      if (state == MUL) result <= mul_out;
      if (rsp_fire) op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - scoreboard bench for mult_share_arb
module tb_mult_share_arb;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_out;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_ready, rsp1_ready;
  logic       busy;
  logic [7:0] op_count;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rsp_cyc = 0;
  logic [8:0] exp_q[$];
  int         g_log[$];
  int         g_cyc[$];
  bit         hold0 = 0, hold1 = 0;
  bit         saw_rsp0 = 0, saw_rsp1 = 0;

  mult_share_arb #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .busy(busy), .op_count(op_count)
  );

  // combinational 4x4 multiplier owned by the parent
  assign mul_out = 8'(mul_a) * 8'(mul_b);

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input int port, input logic [7:0] data);
    logic [8:0] e;
    chk("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rsp_port", port, 32'(e[8]));
      chk("rsp_data", data, 32'(e[7:0]));
    end
    rsp_cyc = cyc;
  endtask

  // sample one cycle just after the falling edge, then advance to the next falling edge
  task automatic step();
    logic       acc0, acc1;
    logic [7:0] p;
    #1;
    cyc++;
    acc0 = req0_ready;
    acc1 = req1_ready;
    if (acc0) begin
      p = 8'(req0_a) * 8'(req0_b);
      exp_q.push_back({1'b0, p});
      g_log.push_back(0);
      g_cyc.push_back(cyc);
    end
    if (acc1) begin
      p = 8'(req1_a) * 8'(req1_b);
      exp_q.push_back({1'b1, p});
      g_log.push_back(1);
      g_cyc.push_back(cyc);
    end
    if (rsp0_valid) saw_rsp0 = 1;
    if (rsp1_valid) saw_rsp1 = 1;
    if (rsp0_valid && rsp0_ready) pop_chk(0, rsp0_data);
    if (rsp1_valid && rsp1_ready) pop_chk(1, rsp1_data);
    @(negedge clk);
    if (acc0 && !hold0) req0_valid = 0;
    if (acc1 && !hold1) req1_valid = 0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req0_valid || req1_valid || busy) && n < max) begin
      step();
      n++;
    end
    chk("drain_idle", {30'd0, busy, exp_q.size() != 0}, 0);
  endtask

  initial begin
    int n;
    rst_n = 0;
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1; req1_a = 4'd1; req1_b = 4'd1;
    rsp0_ready = 1; rsp1_ready = 1;

    // reset state with both requesters asserting
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    rst_n = 1;
    @(negedge clk);

    // single request 2*3
    req0_a = 4'd2; req0_b = 4'd3; req0_valid = 1;
    #1 chk("single_ready", req0_ready, 1);
    step();
    #1;
    chk("single_ready_drop", req0_ready, 0);
    chk("single_busy", busy, 1);
    chk("single_mul_a", mul_a, 2);
    chk("single_mul_b", mul_b, 3);
    step();
    step();
    chk("single_latency", rsp_cyc - g_cyc[$], 2);
    #1 chk("single_op_count", op_count, 1);
    chk("single_idle", busy, 0);

    // corner products on requester 1
    saw_rsp0 = 0;
    req1_a = 4'd13; req1_b = 4'd11; req1_valid = 1; drain(20);
    req1_a = 4'd15; req1_b = 4'd15; req1_valid = 1; drain(20);
    req1_a = 4'd0;  req1_b = 4'd9;  req1_valid = 1; drain(20);
    chk("corner_rsp0_quiet", saw_rsp0, 0);
    chk("corner_op_count", op_count, 4);

    // contention with both valids held
    g_log.delete(); g_cyc.delete();
    hold0 = 1; hold1 = 1;
    req0_a = 4'd4;  req0_b = 4'd8;  req0_valid = 1;
    req1_a = 4'd10; req1_b = 4'd6;  req1_valid = 1;
    n = 0;
    while (g_log.size() < 4 && n < 30) begin step(); n++; end
    chk("cont_grants", g_log.size(), 4);
    hold0 = 0; hold1 = 0;
    req0_valid = 0; req1_valid = 0;
    drain(20);
    if (g_log.size() == 4) begin
      chk("cont_g0", g_log[0], 0);
      chk("cont_g1", g_log[1], 1);
      chk("cont_g2", g_log[2], 0);
      chk("cont_g3", g_log[3], 1);
      chk("cont_space01", g_cyc[1] - g_cyc[0], 3);
      chk("cont_space12", g_cyc[2] - g_cyc[1], 3);
      chk("cont_space23", g_cyc[3] - g_cyc[2], 3);
    end
    chk("cont_op_count", op_count, 8);

    // response backpressure on requester 0
    rsp0_ready = 0;
    req0_a = 4'd5; req0_b = 4'd7; req0_valid = 1;
    step();
    req1_a = 4'd3; req1_b = 4'd3; req1_valid = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", rsp0_valid, 1);
      chk("bp_data", rsp0_data, 35);
      chk("bp_busy", busy, 1);
      chk("bp_req1_ready", req1_ready, 0);
      step();
    end
    rsp0_ready = 1;
    step();
    step();
    chk("bp_next_grant_port", g_log[$], 1);
    chk("bp_next_grant_gap", g_cyc[$] - rsp_cyc, 1);
    drain(20);
    chk("bp_op_count", op_count, 10);

    // reset pulse during MUL from a requester-0 operation
    req0_a = 4'd9; req0_b = 4'd9; req0_valid = 1;
    step();
    #1 rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mul_a", mul_a, 0);
    chk("midrst_mul_b", mul_b, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_rsp0_valid", rsp0_valid, 0);
    #1 rst_n = 1;
    exp_q.delete();
    saw_rsp0 = 0; saw_rsp1 = 0;
    @(negedge clk);
    repeat (3) step();
    chk("midrst_no_rsp", {saw_rsp1, saw_rsp0}, 0);
    chk("midrst_count_hold", op_count, 0);
    g_log.delete(); g_cyc.delete();
    hold0 = 1; hold1 = 1;
    req0_a = 4'd6; req0_b = 4'd7; req0_valid = 1;
    req1_a = 4'd2; req1_b = 4'd2; req1_valid = 1;
    n = 0;
    while (g_log.size() < 1 && n < 10) begin step(); n++; end
    chk("midrst_first_grant", g_log.size() == 1 ? g_log[0] : -1, 0);
    hold0 = 0; hold1 = 0;
    req0_valid = 0; req1_valid = 0;
    drain(20);
    chk("midrst_op_count", op_count, 1);

    // op_count wrap
    for (int i = 0; i < 254; i++) begin
      if (i % 2 == 0) begin
        req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15)); req0_valid = 1;
      end else begin
        req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); req1_valid = 1;
      end
      drain(20);
    end
    chk("wrap_255", op_count, 255);
    req1_a = 4'd15; req1_b = 4'd14; req1_valid = 1;
    drain(20);
    chk("wrap_0", op_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
